// File: rtl/piezo_tone_decoder_if.sv
// Tone-line loopback bundle: square-wave input plus the decoded note report.
// The decoder takes the slave side; the tone source/observer takes the master side.
interface piezo_tone_decoder_if;
  logic       TONE_IN;
  logic       NOTE_VALID;
  logic [3:0] NOTE_CODE;
  logic       SILENCE;
  logic [7:0] HALF_PERIOD;

  modport master (
    output TONE_IN,
    input  NOTE_VALID,
    input  NOTE_CODE,
    input  SILENCE,
    input  HALF_PERIOD
  );

  modport slave (
    input  TONE_IN,
    output NOTE_VALID,
    output NOTE_CODE,
    output SILENCE,
    output HALF_PERIOD
  );
endinterface

// File: rtl/piezo_tone_decoder.sv
// Measures TONE_IN half-periods, classifies them into the DO..HDO scale and
// reports note changes once two consecutive half-periods agree.
module piezo_tone_decoder #(
  parameter int TOL         = 2,
  parameter int SILENCE_CYC = 400,
  parameter int CNT_W       = 9
) (
  input  logic                 CLK,
  input  logic                 RESET,
  piezo_tone_decoder_if.slave  tone
);

  typedef enum logic [1:0] {
    SILENT,
    ACQUIRE,
    CANDIDATE,
    LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] SIL_MAX = CNT_W'(SILENCE_CYC);
  localparam logic [3:0]       UNKNOWN = 4'd15;
  localparam int NOM [8] = '{190, 169, 151, 142, 127, 113, 100, 95};

  state_t           state;
  state_t           state_n;
  logic             sync1;
  logic             sync2;
  logic             hist;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cand;
  logic [3:0]       cand_n;
  logic [3:0]       code;
  logic [3:0]       code_n;
  logic             valid;
  logic             valid_n;
  logic [7:0]       hp;
  logic [7:0]       hp_n;
  logic [7:0]       m_sat;
  logic [3:0]       cls;
  logic             tone_edge;
  logic             timeout;

  function automatic logic [3:0] classify(input logic [CNT_W-1:0] m);
    logic [3:0] c;
    int         d;
    c = UNKNOWN;
    if (int'(m) <= 255) begin
      for (int i = 0; i < 8; i++) begin
        d = int'(m) - NOM[i];
        if (d <= TOL && d >= -TOL) c = 4'(i + 1);
      end
    end
    return c;
  endfunction

  assign tone_edge = sync2 ^ hist;
  // an edge landing on the saturation cycle wins over the timeout
  assign timeout   = (cnt == SIL_MAX) && !tone_edge;
  assign cls       = classify(cnt);
  assign m_sat     = (int'(cnt) > 255) ? 8'hFF : cnt[7:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= tone.TONE_IN;
      sync2 <= sync1;
      hist  <= sync2;
      if (tone_edge)
        cnt <= '0;
      else if (cnt != SIL_MAX)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= SILENT;
      cand  <= UNKNOWN;
      code  <= 4'd0;
      valid <= 1'b0;
      hp    <= 8'd0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      code  <= code_n;
      valid <= valid_n;
      hp    <= hp_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    code_n  = code;
    valid_n = 1'b0;
    hp_n    = hp;
    unique case (state)
      SILENT: begin
        if (tone_edge) state_n = ACQUIRE;
      end
      ACQUIRE: begin
        if (tone_edge) begin
          state_n = CANDIDATE;
          cand_n  = cls;
          hp_n    = m_sat;
        end else if (timeout) begin
          state_n = SILENT;
          if (code != 4'd0) begin
            code_n  = 4'd0;
            valid_n = 1'b1;
          end
        end
      end
      CANDIDATE: begin
        if (tone_edge) begin
          hp_n = m_sat;
          if (cls == cand && cand != UNKNOWN) begin
            state_n = LOCKED;
            if (cand != code) begin
              code_n  = cand;
              valid_n = 1'b1;
            end
          end else begin
            cand_n = cls;
          end
        end else if (timeout) begin
          state_n = SILENT;
          if (code != 4'd0) begin
            code_n  = 4'd0;
            valid_n = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (tone_edge) begin
          hp_n = m_sat;
          if (cls != cand) begin
            state_n = CANDIDATE;
            cand_n  = cls;
          end
        end else if (timeout) begin
          state_n = SILENT;
          if (code != 4'd0) begin
            code_n  = 4'd0;
            valid_n = 1'b1;
          end
        end
      end
      default: state_n = SILENT;
    endcase
  end

  assign tone.NOTE_VALID  = valid;
  assign tone.NOTE_CODE   = code;
  assign tone.SILENCE     = (state == SILENT) || (state == ACQUIRE);
  assign tone.HALF_PERIOD = hp;

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// Scoreboard bench for piezo_tone_decoder: tone intervals in, expected note
// reports derived from half-period rules, monitor compares each pulse.
module tb_piezo_tone_decoder;

  logic CLK = 1'b0;
  logic RESET;

  piezo_tone_decoder_if tone();

  piezo_tone_decoder #(
    .TOL(2),
    .SILENCE_CYC(400),
    .CNT_W(9)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .tone(tone)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cyc;
    int code;
    int hp;
    int sil;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  const int NOM [8] = '{190, 169, 151, 142, 127, 113, 100, 95};

  // reference: tracked per toggle, not per clock
  bit armed;
  int prev;
  int code_m;
  int hp_m;
  int nmeas;
  int last;
  int settle;

  always @(posedge CLK) cyc = cyc + 1;

  function automatic int ref_class(int m);
    if (m > 255) return 15;
    for (int i = 0; i < 8; i++)
      if (m - NOM[i] <= 2 && NOM[i] - m <= 2) return i + 1;
    return 15;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(int c, int code, int hp, int sil);
    exp_t e;
    e.cyc  = c;
    e.code = code;
    e.hp   = hp;
    e.sil  = sil;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    armed  = 1'b0;
    prev   = 15;
    code_m = 0;
    hp_m   = 0;
    nmeas  = 0;
    last   = cyc;
    settle = cyc;
  endtask

  task automatic model_edge(int t);
    int m;
    int c;
    if (!armed) begin
      armed = 1'b1;
      prev  = 15;
      nmeas = 0;
    end else begin
      m    = t - last - 1;
      c    = ref_class(m);
      hp_m = (m > 255) ? 255 : m;
      nmeas++;
      if (c != 15 && c == prev && c != code_m) begin
        code_m = c;
        push_exp(t + 3, c, hp_m, 0);
      end
      prev = c;
    end
    last   = t;
    settle = t + 3;
  endtask

  task automatic check_state(string tag);
    if (cyc >= settle) begin
      check({tag, "_silence"}, int'(tone.SILENCE),
            (armed && nmeas > 0) ? 0 : 1);
      check({tag, "_code"}, int'(tone.NOTE_CODE), code_m);
      check({tag, "_half_period"}, int'(tone.HALF_PERIOD), hp_m);
    end
  endtask

  task automatic toggle();
    check_state("pre_edge");
    tone.TONE_IN = ~tone.TONE_IN;
    model_edge(cyc);
  endtask

  task automatic gap(int n);
    if (armed && cyc + n - last > 401) begin
      if (code_m != 0) begin
        code_m = 0;
        push_exp(last + 404, 0, hp_m, 1);
      end
      armed  = 1'b0;
      nmeas  = 0;
      settle = last + 404;
    end
    repeat (n) @(negedge CLK);
  endtask

  task automatic intervals(int k, int reps);
    for (int i = 0; i < reps; i++) begin
      gap(k);
      toggle();
    end
  endtask

  task automatic apply_reset(int n);
    RESET        = 1'b1;
    tone.TONE_IN = 1'b0;
    @(negedge CLK);
    check("reset_valid", int'(tone.NOTE_VALID), 0);
    check("reset_code", int'(tone.NOTE_CODE), 0);
    check("reset_silence", int'(tone.SILENCE), 1);
    check("reset_half_period", int'(tone.HALF_PERIOD), 0);
    repeat (n - 1) @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RESET) begin
      if (tone.NOTE_VALID) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: code %0d at cycle %0d, expected none",
                   tone.NOTE_CODE, cyc);
        end else begin
          e = sb.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_code", int'(tone.NOTE_CODE), e.code);
          check("pulse_half_period", int'(tone.HALF_PERIOD), e.hp);
          check("pulse_silence", int'(tone.SILENCE), e.sil);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        e = sb.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_pulse: none by cycle %0d, expected code %0d at cycle %0d",
                 cyc, e.code, e.cyc);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int note;
    int reps;
    int off;
    tone.TONE_IN = 1'b0;
    RESET        = 1'b1;
    model_reset();
    apply_reset(3);

    toggle();
    intervals(152, 22);
    intervals(170, 4);
    intervals(98, 3);
    intervals(99, 3);
    intervals(121, 3);
    intervals(152, 3);
    gap(600);
    check_state("after_timeout");

    toggle();
    intervals(191, 3);
    gap(10);
    check_state("locked_do");
    apply_reset(2);
    toggle();
    intervals(191, 2);
    gap(10);
    check_state("relock_do");

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        note = $urandom_range(0, 7);
        reps = $urandom_range(1, 4);
        for (int j = 0; j < reps; j++) begin
          off = $urandom_range(0, 6) - 3;
          intervals(NOM[note] + off + 1, 1);
        end
      end else if (r < 9) begin
        intervals($urandom_range(60, 300), 1);
      end else begin
        gap($urandom_range(420, 700));
        toggle();
      end
    end

    gap(600);
    check_state("final");
    repeat (10) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
